pkg_drop_sched: RTL and testbench



---
 rtl/pkg_drop_sched.sv | 160 ++++++++++++++++
 tb/tb_pkg_drop_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkg_drop_sched.sv
// Round-robin drop scheduler: grants one port's drop request at a time, walks the
// packet's linked list through the shared lookup port and recycles each freed block.
//
// state    | meaning
// S_IDLE   | arbitrate the four drop requests
// S_LOOKUP | recycle last block, or issue next-pointer read for rCur
// S_WAIT   | wait for next-pointer reply, abort after TIMEOUT_CYC cycles
module pkg_drop_sched #(
  parameter int ADDR_LENTH  = 12,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [ADDR_LENTH-1:0] iPkgFirAddr0,
  input  logic [ADDR_LENTH-1:0] iPkgFirAddr1,
  input  logic [ADDR_LENTH-1:0] iPkgFirAddr2,
  input  logic [ADDR_LENTH-1:0] iPkgFirAddr3,
  input  logic [3:0]            iPkgBlockNum0,
  input  logic [3:0]            iPkgBlockNum1,
  input  logic [3:0]            iPkgBlockNum2,
  input  logic [3:0]            iPkgBlockNum3,
  input  logic                  iPkgDropVld0,
  input  logic                  iPkgDropVld1,
  input  logic                  iPkgDropVld2,
  input  logic                  iPkgDropVld3,
  output logic                  oPkgDropRdy0,
  output logic                  oPkgDropRdy1,
  output logic                  oPkgDropRdy2,
  output logic                  oPkgDropRdy3,
  output logic [ADDR_LENTH-1:0] oDropAddr,
  output logic                  oDropAddrVld,
  input  logic [ADDR_LENTH-1:0] iDropData,
  input  logic                  iDropDataVld,
  output logic [ADDR_LENTH-1:0] oRcvrAddr,
  output logic                  oRcvrAddrVld,
  output logic                  oBusy,
  output logic                  oTimeout,
  output logic [CNT_WIDTH-1:0]  oFreedCnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WAIT} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t                state;
  logic [ADDR_LENTH-1:0] rCur;
  logic [3:0]            rRem;
  logic [7:0]            rTmo;
  logic [1:0]            rPtr;

  logic [3:0]            vld;
  logic [ADDR_LENTH-1:0] fir [4];
  logic [3:0]            num [4];
  logic [3:0]            rdy;
  logic [1:0]            gnt_idx;
  logic [1:0]            scan_idx;
  logic                  gnt_any;

  assign vld    = {iPkgDropVld3, iPkgDropVld2, iPkgDropVld1, iPkgDropVld0};
  assign fir[0] = iPkgFirAddr0;
  assign fir[1] = iPkgFirAddr1;
  assign fir[2] = iPkgFirAddr2;
  assign fir[3] = iPkgFirAddr3;
  assign num[0] = iPkgBlockNum0;
  assign num[1] = iPkgBlockNum1;
  assign num[2] = iPkgBlockNum2;
  assign num[3] = iPkgBlockNum3;

  // Ready is held off during reset so a requester never sees an accept that reset discards.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = 2'd0;
    scan_idx = 2'd0;
    rdy      = 4'b0000;
    if (state == S_IDLE && iRst_n) begin
      for (int i = 0; i < 4; i++) begin
        scan_idx = rPtr + 2'(i);
        if (!gnt_any && vld[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
    if (gnt_any) rdy[gnt_idx] = 1'b1;
  end

  assign oPkgDropRdy0 = rdy[0];
  assign oPkgDropRdy1 = rdy[1];
  assign oPkgDropRdy2 = rdy[2];
  assign oPkgDropRdy3 = rdy[3];

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state        <= S_IDLE;
      rCur         <= '0;
      rRem         <= '0;
      rTmo         <= '0;
      rPtr         <= '0;
      oDropAddr    <= '0;
      oDropAddrVld <= 1'b0;
      oRcvrAddr    <= '0;
      oRcvrAddrVld <= 1'b0;
      oBusy        <= 1'b0;
      oTimeout     <= 1'b0;
      oFreedCnt    <= '0;
    end else begin
      oDropAddrVld <= 1'b0;
      oRcvrAddrVld <= 1'b0;
      oTimeout     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            rCur  <= fir[gnt_idx];
            rRem  <= num[gnt_idx];
            rPtr  <= gnt_idx + 2'd1;
            state <= S_LOOKUP;
            oBusy <= 1'b1;
          end
        end
        S_LOOKUP: begin
          if (rRem == 4'd0) begin
            oRcvrAddr    <= rCur;
            oRcvrAddrVld <= 1'b1;
            oFreedCnt    <= oFreedCnt + 1'b1;
            state        <= S_IDLE;
            oBusy        <= 1'b0;
          end else begin
            oDropAddr    <= rCur;
            oDropAddrVld <= 1'b1;
            rTmo         <= 8'd0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A block is freed only once its next pointer has been captured.
          if (iDropDataVld) begin
            oRcvrAddr    <= rCur;
            oRcvrAddrVld <= 1'b1;
            oFreedCnt    <= oFreedCnt + 1'b1;
            rCur         <= iDropData;
            rRem         <= rRem - 4'd1;
            state        <= S_LOOKUP;
          end else if (rTmo == TMO_LAST) begin
            oTimeout <= 1'b1;
            state    <= S_IDLE;
            oBusy    <= 1'b0;
          end else begin
            rTmo <= rTmo + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkg_drop_sched.sv
// Bench for pkg_drop_sched: per-cycle schedule model derived from grant/latency rules,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pkg_drop_sched;
  localparam int AW   = 12;
  localparam int CW   = 6;
  localparam int TMO  = 15;
  localparam int MAXC = 8192;

  logic iClk = 1'b0;
  always #5 iClk = ~iClk;

  logic          iRst_n;
  logic [AW-1:0] fir_p [4];
  logic [3:0]    num_p [4];
  logic          vld_p [4];
  logic          rdy_p [4];
  logic [AW-1:0] oDropAddr, iDropData, oRcvrAddr;
  logic          oDropAddrVld, iDropDataVld, oRcvrAddrVld, oBusy, oTimeout;
  logic [CW-1:0] oFreedCnt;

  pkg_drop_sched #(.ADDR_LENTH(AW), .CNT_WIDTH(CW), .TIMEOUT_CYC(TMO)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iPkgFirAddr0(fir_p[0]), .iPkgFirAddr1(fir_p[1]),
    .iPkgFirAddr2(fir_p[2]), .iPkgFirAddr3(fir_p[3]),
    .iPkgBlockNum0(num_p[0]), .iPkgBlockNum1(num_p[1]),
    .iPkgBlockNum2(num_p[2]), .iPkgBlockNum3(num_p[3]),
    .iPkgDropVld0(vld_p[0]), .iPkgDropVld1(vld_p[1]),
    .iPkgDropVld2(vld_p[2]), .iPkgDropVld3(vld_p[3]),
    .oPkgDropRdy0(rdy_p[0]), .oPkgDropRdy1(rdy_p[1]),
    .oPkgDropRdy2(rdy_p[2]), .oPkgDropRdy3(rdy_p[3]),
    .oDropAddr(oDropAddr), .oDropAddrVld(oDropAddrVld),
    .iDropData(iDropData), .iDropDataVld(iDropDataVld),
    .oRcvrAddr(oRcvrAddr), .oRcvrAddrVld(oRcvrAddrVld),
    .oBusy(oBusy), .oTimeout(oTimeout), .oFreedCnt(oFreedCnt)
  );

  // Expected per-cycle events and scheduled SRAM replies.
  bit            e_dv [MAXC];
  bit            e_rv [MAXC];
  bit            e_to [MAXC];
  bit            e_busy [MAXC];
  logic [AW-1:0] e_da [MAXC];
  logic [AW-1:0] e_ra [MAXC];
  bit            s_vld [MAXC];
  logic [AW-1:0] s_data [MAXC];

  int            cyc = 0;
  int            idle_from = 0;
  int            rr = 0;
  logic [AW-1:0] h_da = '0, h_ra = '0;
  logic [CW-1:0] m_cnt = '0;

  bit            req_vld [4];
  int            req_fir [4];
  int            req_num [4];
  int            rst_cnt = 0;
  bit            rand_mode = 0, chain_inc = 1, stray_once = 0;
  int            fixed_lat = 1;

  int n_tests = 0, n_fail = 0;

  int obs_da [64], da_cyc [64], n_da;
  int obs_ra [64], ra_cyc [64], n_ra;
  int obs_gr [64], gr_cyc [64], n_gr;
  int to_cyc [64], n_to;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_obs();
    n_da = 0; n_ra = 0; n_gr = 0; n_to = 0;
    for (int i = 0; i < 64; i++) begin
      obs_da[i] = -1; obs_ra[i] = -1; obs_gr[i] = -1;
      da_cyc[i] = -1; ra_cyc[i] = -1; gr_cyc[i] = -1; to_cyc[i] = -1;
    end
  endtask

  function automatic int pick_lat();
    int r;
    if (fixed_lat >= 0) return fixed_lat;
    r = $urandom_range(0, 31);
    if (r == 0) return 99;
    if (r == 1) return TMO - 1;
    return r % 4;
  endfunction

  task automatic model_reset(input int c0);
    for (int c = c0; c < MAXC && c < c0 + 512; c++) begin
      e_dv[c] = 0; e_rv[c] = 0; e_to[c] = 0; e_busy[c] = 0; s_vld[c] = 0;
    end
    idle_from = c0; rr = 0; h_da = '0; h_ra = '0; m_cnt = '0;
  endtask

  // Walk timing: LOOKUP one cycle after accept; strobe next cycle; reply L cycles after
  // strobe; block recycled the cycle after its reply; last block recycled after LOOKUP.
  task automatic schedule(input int k, input logic [AW-1:0] a0, input int num);
    int t, s, l, last;
    logic [AW-1:0] a, nxt;
    bit done;
    t = k + 1; a = a0; done = 0; last = t;
    for (int i = 0; i <= num && !done; i++) begin
      if (i == num) begin
        e_rv[t+1] = 1; e_ra[t+1] = a; last = t; idle_from = t + 1; done = 1;
      end else begin
        s = t + 1; e_dv[s] = 1; e_da[s] = a; l = pick_lat();
        if (l >= TMO) begin
          e_to[s+TMO] = 1; last = s + TMO - 1; idle_from = s + TMO; done = 1;
        end else begin
          nxt = chain_inc ? a + AW'(1) : AW'($urandom);
          s_vld[s+l] = 1; s_data[s+l] = nxt;
          e_rv[s+l+1] = 1; e_ra[s+l+1] = a;
          a = nxt; t = s + l + 1;
        end
      end
    end
    for (int c = k + 1; c <= last; c++) e_busy[c] = 1;
  endtask

  task automatic check_cycle(input int k);
    if (e_dv[k]) h_da = e_da[k];
    if (e_rv[k]) begin h_ra = e_ra[k]; m_cnt = m_cnt + 1'b1; end
    chk("drop_vld", oDropAddrVld, e_dv[k]);
    chk("drop_addr", oDropAddr, h_da);
    chk("rcvr_vld", oRcvrAddrVld, e_rv[k]);
    chk("rcvr_addr", oRcvrAddr, h_ra);
    chk("timeout", oTimeout, e_to[k]);
    chk("busy", oBusy, e_busy[k]);
    chk("freed_cnt", oFreedCnt, m_cnt);
    if (oDropAddrVld === 1'b1 && n_da < 64) begin obs_da[n_da] = oDropAddr; da_cyc[n_da] = k; n_da++; end
    if (oRcvrAddrVld === 1'b1 && n_ra < 64) begin obs_ra[n_ra] = oRcvrAddr; ra_cyc[n_ra] = k; n_ra++; end
    if (oTimeout === 1'b1 && n_to < 64) begin to_cyc[n_to] = k; n_to++; end
  endtask

  task automatic drive_cycle(input int k);
    logic [3:0] exp_rdy, act_rdy;
    int g, p;
    iRst_n = 1'b1;
    if (rst_cnt > 0) begin
      iRst_n = 1'b0; rst_cnt--;
    end else if (rand_mode && e_busy[k] && $urandom_range(0, 199) == 0) begin
      iRst_n = 1'b0;
    end
    if (rand_mode) begin
      for (int n = 0; n < 4; n++) begin
        if (!req_vld[n] && $urandom_range(0, 3) == 0) begin
          req_vld[n] = 1; req_fir[n] = $urandom_range(0, 4095);
          req_num[n] = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
        end
      end
    end
    for (int n = 0; n < 4; n++) begin
      vld_p[n] = req_vld[n];
      fir_p[n] = req_vld[n] ? AW'(req_fir[n]) : AW'($urandom);
      num_p[n] = req_vld[n] ? 4'(req_num[n]) : 4'($urandom);
    end
    iDropDataVld = s_vld[k];
    iDropData    = s_vld[k] ? s_data[k] : AW'($urandom);
    if (!s_vld[k] && k >= idle_from && (stray_once || (rand_mode && $urandom_range(0, 9) == 0))) begin
      iDropDataVld = 1'b1; stray_once = 0;
    end
    #1;
    exp_rdy = 4'b0; g = -1;
    if (iRst_n && k >= idle_from) begin
      for (int i = 0; i < 4; i++) begin
        p = (rr + i) % 4;
        if (g < 0 && req_vld[p]) g = p;
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    act_rdy = {rdy_p[3], rdy_p[2], rdy_p[1], rdy_p[0]};
    chk("ready", act_rdy, exp_rdy);
    for (int n = 0; n < 4; n++)
      if (act_rdy[n] === 1'b1 && n_gr < 64) begin obs_gr[n_gr] = n; gr_cyc[n_gr] = k; n_gr++; end
    if (g >= 0) begin
      req_vld[g] = 0; rr = (g + 1) % 4;
      schedule(k, AW'(req_fir[g]), req_num[g]);
    end
    if (!iRst_n) model_reset(k + 1);
  endtask

  task automatic step();
    @(posedge iClk);
    cyc++;
    @(negedge iClk);
    check_cycle(cyc);
    drive_cycle(cyc);
  endtask

  task automatic set_req(input int n, input int a, input int b);
    req_vld[n] = 1; req_fir[n] = a; req_num[n] = b;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (cyc >= idle_from && !(req_vld[0] || req_vld[1] || req_vld[2] || req_vld[3])) done = 1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle cyc=%0d got=busy exp=idle within %0d cycles", cyc, budget);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int n = 0; n < 4; n++) begin req_vld[n] = 0; req_fir[n] = 0; req_num[n] = 0; end
    clear_obs();
    rst_cnt = 3;
    drive_cycle(0);
    repeat (4) step();
    chk("reset_busy", oBusy, 0);
    chk("reset_cnt", oFreedCnt, 0);

    // Three-block walk, SRAM replies addr+1 one cycle after strobe.
    clear_obs(); chain_inc = 1; fixed_lat = 1;
    set_req(1, 20, 2); wait_idle(200);
    chk("p1_ngrant", n_gr, 1);      chk("p1_grant", obs_gr[0], 1);
    chk("p1_nda", n_da, 2);         chk("p1_da0", obs_da[0], 20); chk("p1_da1", obs_da[1], 21);
    chk("p1_nra", n_ra, 3);         chk("p1_ra0", obs_ra[0], 20);
    chk("p1_ra1", obs_ra[1], 21);   chk("p1_ra2", obs_ra[2], 22);
    chk("p1_cnt", oFreedCnt, 3);    chk("p1_busy", oBusy, 0);
    chk("p1_latency", ra_cyc[2] - gr_cyc[0], 8);

    // All four ports at once after reset, single-block packets.
    rst_cnt = 1; step();
    clear_obs(); fixed_lat = 0;
    set_req(0, 1, 0); set_req(1, 20, 0); set_req(2, 35, 0); set_req(3, 70, 0);
    wait_idle(200);
    chk("p2_ngrant", n_gr, 4);
    chk("p2_g0", obs_gr[0], 0); chk("p2_g1", obs_gr[1], 1);
    chk("p2_g2", obs_gr[2], 2); chk("p2_g3", obs_gr[3], 3);
    chk("p2_ra0", obs_ra[0], 1);  chk("p2_ra1", obs_ra[1], 20);
    chk("p2_ra2", obs_ra[2], 35); chk("p2_ra3", obs_ra[3], 70);
    chk("p2_gap", ra_cyc[1] - ra_cyc[0], 2);
    chk("p2_span", ra_cyc[3] - ra_cyc[0], 6);
    chk("p2_cnt", oFreedCnt, 4);

    // Rotation: after port 2, port 3 outranks port 0.
    clear_obs();
    set_req(2, 300, 0); wait_idle(100);
    set_req(0, 400, 0); set_req(3, 500, 0); wait_idle(100);
    chk("p3_ngrant", n_gr, 3);
    chk("p3_g0", obs_gr[0], 2); chk("p3_g1", obs_gr[1], 3); chk("p3_g2", obs_gr[2], 0);

    // SRAM never replies: abort 15 cycles after WAIT entry, nothing recycled.
    clear_obs(); fixed_lat = 99;
    set_req(0, 5, 1); wait_idle(100);
    chk("p4_nda", n_da, 1);  chk("p4_da0", obs_da[0], 5);
    chk("p4_nra", n_ra, 0);  chk("p4_nto", n_to, 1);
    chk("p4_tmo_delay", to_cyc[0] - da_cyc[0], 15);
    chk("p4_busy", oBusy, 0);

    // Stray reply in IDLE is ignored.
    clear_obs(); fixed_lat = 2; stray_once = 1;
    step(); step();
    set_req(1, 9, 1); wait_idle(100);
    chk("p5_nra", n_ra, 2); chk("p5_ra0", obs_ra[0], 9); chk("p5_ra1", obs_ra[1], 10);

    // Reset during WAIT discards the walk; next request serviced normally.
    clear_obs(); fixed_lat = 5;
    set_req(0, 100, 3);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin step(); if (n_da >= 1) seen = 1; end
    chk("p6_strobe_seen", seen, 1);
    step();
    rst_cnt = 1; step();
    step();
    chk("p6_rst_cnt", oFreedCnt, 0); chk("p6_rst_busy", oBusy, 0); chk("p6_nra", n_ra, 0);
    set_req(3, 200, 0); wait_idle(100);
    chk("p6_ngrant", n_gr, 2); chk("p6_g1", obs_gr[1], 3);
    chk("p6_ra0", obs_ra[0], 200); chk("p6_cnt", oFreedCnt, 1);

    // Randomized traffic: random chains, latencies (incl. last-chance and timeout), resets.
    chain_inc = 0; fixed_lat = -1; rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    wait_idle(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
